irq_pending_latch: RTL and testbench

//  Stage directly upstream of the 8-to-3 priority encoder in the interrupt path.
//  - Synchronizes 8 asynchronous request lines and edge-detects them.
//  - Latches each rising edge as a pending bit, applies a per-line mask, and drives the

---
 rtl/irq_pending_latch.sv | 135 +++++++++++++
 tb/tb_irq_pending_latch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_latch
// Brief    : Synchronizes and edge-latches 8 interrupt lines, masks them for
//            the downstream priority encoder, and presents one id at a time
//            over a valid/ack handshake (line 0 highest priority).
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic [7:0] mask,
    input  logic       irq_ack,
    input  logic       lost_clr,
    output logic [7:0] pend_vec,
    output logic       enc_en,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] irq_lost
);

    localparam int c_CNT_W = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  edge_q, edge_d;
    logic [7:0]                  pending_q, pending_d;
    logic [7:0]                  pend_vec_q, pend_vec_d;
    logic                        enc_en_q, enc_en_d;
    logic [7:0]                  lost_q, lost_d;
    logic                        valid_q, valid_d;
    logic [2:0]                  id_q, id_d;
    logic [c_CNT_W-1:0]          cnt_q, cnt_d;
    state_t                      state_q, state_d;

    logic [7:0] w_rise;
    logic [7:0] w_clr;
    logic       w_ack_hit;

    // Lowest set index wins, matching the downstream encoder.
    function automatic logic [2:0] encode(input logic [7:0] v);
        encode = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) encode = 3'(i);
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        w_ack_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_en_q) begin
                    valid_d = 1'b1;
                    id_d    = encode(pend_vec_q);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_ack_hit = 1'b1;
                    valid_d   = 1'b0;
                    cnt_d     = c_CNT_W'(MIN_GAP);
                    state_d   = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q - c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A rise on the same edge as the ack re-arms the line rather than counting as lost.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
        edge_d     = sync_q[SYNC_STAGES-1];
        w_rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
        w_clr      = w_ack_hit ? (8'd1 << id_q) : 8'd0;
        pending_d  = (pending_q & ~w_clr) | w_rise;
        lost_d     = (lost_clr ? 8'd0 : lost_q) | (w_rise & pending_q & ~w_clr);
        pend_vec_d = pending_q & ~mask;
        enc_en_d   = |pend_vec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            edge_q     <= 8'd0;
            pending_q  <= 8'd0;
            pend_vec_q <= 8'd0;
            enc_en_q   <= 1'b0;
            lost_q     <= 8'd0;
            valid_q    <= 1'b0;
            id_q       <= 3'd0;
            cnt_q      <= '0;
            state_q    <= IDLE;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            pending_q  <= pending_d;
            pend_vec_q <= pend_vec_d;
            enc_en_q   <= enc_en_d;
            lost_q     <= lost_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign pend_vec  = pend_vec_q;
    assign enc_en    = enc_en_q;
    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign irq_lost  = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_latch
// Brief    : Scoreboard bench for irq_pending_latch (expected ids queued at
//            stimulus time, popped as each id is presented).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_latch;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_GAP     = 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       lost_clr;
    logic [7:0] pend_vec;
    logic       enc_en;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] irq_lost;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int t_prev   = 0;
    int exp_q[$];

    irq_pending_latch #(
        .SYNC_STAGES(SYNC_STAGES),
        .MIN_GAP    (MIN_GAP)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .mask     (mask),
        .irq_ack  (irq_ack),
        .lost_clr (lost_clr),
        .pend_vec (pend_vec),
        .enc_en   (enc_en),
        .irq_valid(irq_valid),
        .irq_id   (irq_id),
        .irq_lost (irq_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!irq_valid && n < 40) begin
            cyc(1);
            n++;
        end
        if (!irq_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_chk(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(irq_id), 32'(e));
        end
    endtask

    // Waits for a presented id, scores it, and acks it for one cycle.
    task automatic serve(input string tag, input bit gapchk);
        wait_valid(tag);
        if (irq_valid) begin
            pop_chk(tag);
            if (gapchk) chk({tag, "_spacing"}, 32'(cyc_cnt - t_prev), 32'(MIN_GAP + 2));
            t_prev  = cyc_cnt;
            irq_ack = 1'b1;
            cyc(1);
            irq_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_in   = 8'h00;
        mask     = 8'h00;
        irq_ack  = 1'b0;
        lost_clr = 1'b0;

        // 1. reset state, edge during reset ignored
        #12 irq_in[5] = 1'b1;
        #20 irq_in[5] = 1'b0;
        chk("rst_pend_vec", 32'(pend_vec), 32'h0);
        chk("rst_enc_en", 32'(enc_en), 32'h0);
        chk("rst_valid", 32'(irq_valid), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);
        chk("rst_lost", 32'(irq_lost), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(6);
        chk("rst_pulse_pend", 32'(pend_vec), 32'h0);
        chk("rst_pulse_valid", 32'(irq_valid), 32'h0);

        // 2. single event, exact latency
        irq_in = 8'h08;
        exp_q.push_back(3);
        cyc(SYNC_STAGES + 1);
        chk("t2_pend_early", 32'(pend_vec), 32'h00);
        cyc(1);
        chk("t2_pend_vec", 32'(pend_vec), 32'h08);
        chk("t2_enc_en", 32'(enc_en), 32'h1);
        chk("t2_valid_early", 32'(irq_valid), 32'h0);
        cyc(1);
        chk("t2_valid", 32'(irq_valid), 32'h1);
        serve("t2_id", 1'b0);
        chk("t2_valid_drop", 32'(irq_valid), 32'h0);
        cyc(1);
        chk("t2_pend_clr", 32'(pend_vec), 32'h00);
        chk("t2_enc_clr", 32'(enc_en), 32'h0);
        cyc(3);
        chk("t2_stay_idle", 32'(irq_valid), 32'h0);
        irq_in = 8'h00;
        cyc(3);

        // 3. multiple lines together, ordered service and spacing
        irq_in = 8'hA4;
        exp_q.push_back(2);
        exp_q.push_back(5);
        exp_q.push_back(7);
        serve("t3_id_a", 1'b0);
        serve("t3_id_b", 1'b1);
        serve("t3_id_c", 1'b1);
        cyc(3);
        chk("t3_drained", 32'(pend_vec), 32'h00);
        irq_in = 8'h00;
        cyc(3);

        // 4. lost events and lost_clr priority
        irq_in = 8'h02;
        exp_q.push_back(1);
        wait_valid("t4_first");
        chk("t4_id_hold", 32'(irq_id), 32'h1);
        irq_in = 8'h00;
        cyc(3);
        irq_in = 8'h02;
        cyc(4);
        chk("t4_lost_set", 32'(irq_lost), 32'h02);
        chk("t4_valid_held", 32'(irq_valid), 32'h1);
        lost_clr = 1'b1;
        cyc(1);
        lost_clr = 1'b0;
        chk("t4_lost_clr", 32'(irq_lost), 32'h00);
        irq_in = 8'h00;
        cyc(3);
        irq_in = 8'h02;
        cyc(SYNC_STAGES);
        lost_clr = 1'b1;
        cyc(1);
        lost_clr = 1'b0;
        chk("t4_set_wins", 32'(irq_lost), 32'h02);
        lost_clr = 1'b1;
        cyc(1);
        lost_clr = 1'b0;
        chk("t4_lost_clr2", 32'(irq_lost), 32'h00);
        // ack lands on the same edge as a fresh rise
        irq_in = 8'h00;
        cyc(3);
        irq_in = 8'h02;
        cyc(SYNC_STAGES);
        pop_chk("t4_id");
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("t4_ack_rise_nolost", 32'(irq_lost), 32'h00);
        exp_q.push_back(1);
        serve("t4_rerise_id", 1'b0);
        irq_in = 8'h00;
        cyc(4);
        chk("t4_drained", 32'(pend_vec), 32'h00);

        // 5. mask holds lines pending; stray ack ignored
        mask   = 8'hFF;
        irq_in = 8'h41;
        cyc(8);
        chk("t5_masked_pend", 32'(pend_vec), 32'h00);
        chk("t5_masked_en", 32'(enc_en), 32'h0);
        irq_ack = 1'b1;
        cyc(2);
        irq_ack = 1'b0;
        chk("t5_masked_valid", 32'(irq_valid), 32'h0);
        mask = 8'h01;
        exp_q.push_back(6);
        serve("t5_id6", 1'b0);
        mask = 8'h00;
        exp_q.push_back(0);
        serve("t5_id0", 1'b0);
        irq_in = 8'h00;
        cyc(4);
        chk("t5_drained", 32'(pend_vec), 32'h00);

        // 6. id stability during REQ
        irq_in = 8'h10;
        exp_q.push_back(4);
        wait_valid("t6_first");
        chk("t6_id4", 32'(irq_id), 32'h4);
        irq_in = 8'h11;
        exp_q.push_back(0);
        cyc(6);
        chk("t6_id_stable", 32'(irq_id), 32'h4);
        chk("t6_pend_both", 32'(pend_vec), 32'h11);
        mask = 8'h10;
        cyc(2);
        chk("t6_id_masked_stable", 32'(irq_id), 32'h4);
        mask = 8'h00;
        serve("t6_serve4", 1'b0);
        serve("t6_serve0", 1'b0);
        irq_in = 8'h00;
        cyc(3);

        // async reset mid-REQ
        irq_in = 8'h04;
        wait_valid("t6_rst");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(irq_valid), 32'h0);
        chk("t6_rst_pend", 32'(pend_vec), 32'h00);
        chk("t6_rst_id", 32'(irq_id), 32'h0);
        irq_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8);
        chk("t6_post_rst_valid", 32'(irq_valid), 32'h0);
        chk("t6_post_rst_pend", 32'(pend_vec), 32'h00);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
